mult_share_arbiter: RTL and testbench

- Shares one sequential multiplier core (start/ready handshake, 2*L_word-bit product) between N_req requesters.
- Round-robin arbitration; the granted requester's operands are latched and launched with a one-cycle start pulse.
- Waits for the core's ready, captures the product, and returns it to the winner with a one-cycle done pulse and requester ID.
- Sits between client blocks and the multiplier core.

---
 rtl/mult_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares one sequential multiplier core between N_req requesters using
// round-robin arbitration. The winner's operands are latched and handed to
// the core with a one-cycle start pulse. When the core reports ready, the
// product is captured and returned to the winner with a one-cycle done pulse
// and the winner's index.
//
// Optional feature macro: ZERO_BYPASS_EN
//   When defined, an operation whose multiplicand or multiplier is zero skips
//   the core entirely and is delivered with result 0 straight from IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req          per-requester request level (sampled only in IDLE)
//   A_in, x_in   packed operands, requester i uses [i*L_word +: L_word]
//   grant        one-hot owner, held from arbitration until delivery
//   done         one-hot, one-cycle completion pulse
//   result       captured product, held until the next delivery
//   result_id    index of the requester owning result
//   busy         high whenever the FSM is not in IDLE
//   mult_A/x     latched operands driven to the core
//   mult_Start   start pulse to the core
//   mult_Ready   core idle/ready
//   mult_product core product
module mult_share_arbiter #(
  parameter int L_word = 4,
  parameter int N_req  = 2,
  parameter int L_id   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_req-1:0]        req,
  input  logic [N_req*L_word-1:0] A_in,
  input  logic [N_req*L_word-1:0] x_in,
  output logic [N_req-1:0]        grant,
  output logic [N_req-1:0]        done,
  output logic [2*L_word-1:0]     result,
  output logic [L_id-1:0]         result_id,
  output logic                    busy,
  output logic [L_word-1:0]       mult_A,
  output logic [L_word-1:0]       mult_x,
  output logic                    mult_Start,
  input  logic                    mult_Ready,
  input  logic [2*L_word-1:0]     mult_product
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DELIVER
  } state_t;

  state_t            state;
  logic [L_id-1:0]   last;

  logic              any_req;
  logic [L_id-1:0]   winner;
  logic [N_req-1:0]  win_onehot;
  logic [L_word-1:0] win_A;
  logic [L_word-1:0] win_x;

  // Round-robin pick: first search requesters above the last winner, then
  // wrap around to those at or below it, so the last winner ranks lowest.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int j = 0; j < N_req; j++) begin
      if (!any_req && req[j] && (j > int'(last))) begin
        any_req = 1'b1;
        winner  = L_id'(j);
      end
    end
    for (int j = 0; j < N_req; j++) begin
      if (!any_req && req[j] && (j <= int'(last))) begin
        any_req = 1'b1;
        winner  = L_id'(j);
      end
    end
    win_onehot = {{(N_req-1){1'b0}}, 1'b1} << winner;
    win_A      = A_in[int'(winner)*L_word +: L_word];
    win_x      = x_in[int'(winner)*L_word +: L_word];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= L_id'(N_req - 1);
      grant      <= '0;
      done       <= '0;
      result     <= '0;
      result_id  <= '0;
      busy       <= 1'b0;
      mult_A     <= '0;
      mult_x     <= '0;
      mult_Start <= 1'b0;
    end else begin
      done       <= '0;
      mult_Start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= win_onehot;
            last      <= winner;
            result_id <= winner;
            mult_A    <= win_A;
            mult_x    <= win_x;
            busy      <= 1'b1;
`ifdef ZERO_BYPASS_EN
            // A zero operand makes the product trivially zero, so the core
            // is never started and the result is delivered next cycle.
            if ((win_A == '0) || (win_x == '0)) begin
              result <= '0;
              done   <= win_onehot;
              state  <= DELIVER;
            end else begin
              mult_Start <= 1'b1;
              state      <= LAUNCH;
            end
`else
            mult_Start <= 1'b1;
            state      <= LAUNCH;
`endif
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // grant is already the one-hot of result_id, so it doubles as the
          // done pattern.
          if (mult_Ready) begin
            result <= mult_product;
            done   <= grant;
            state  <= DELIVER;
          end
        end
        DELIVER: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//
// Directed bench for mult_share_arbiter with a behavioural multiplier core.
// Expected deliveries are queued when a request is driven and popped when
// done pulses. Build with +define+ZERO_BYPASS_EN to exercise the bypass.
module tb_mult_share_arbiter;

  localparam int LW = 4;
  localparam int NR = 2;
  localparam int LI = 1;

`ifdef ZERO_BYPASS_EN
  localparam int ZLAT   = 1;
  localparam int ZSTART = 0;
`else
  localparam int ZLAT   = 3;
  localparam int ZSTART = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  A_in;
  logic [NR*LW-1:0]  x_in;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [2*LW-1:0]   result;
  logic [LI-1:0]     result_id;
  logic              busy;
  logic [LW-1:0]     mult_A;
  logic [LW-1:0]     mult_x;
  logic              mult_Start;
  logic              mult_Ready;
  logic [2*LW-1:0]   mult_product;

  mult_share_arbiter #(.L_word(LW), .N_req(NR), .L_id(LI)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .A_in         (A_in),
    .x_in         (x_in),
    .grant        (grant),
    .done         (done),
    .result       (result),
    .result_id    (result_id),
    .busy         (busy),
    .mult_A       (mult_A),
    .mult_x       (mult_x),
    .mult_Start   (mult_Start),
    .mult_Ready   (mult_Ready),
    .mult_product (mult_product)
  );

  always #5 clk = ~clk;

  // Behavioural core: busy for busy_cycles edges after a start, then ready.
  int              core_cnt;
  int              busy_cycles;
  logic [2*LW-1:0] core_prod;

  assign mult_Ready   = (core_cnt == 0);
  assign mult_product = core_prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt  <= 0;
      core_prod <= '0;
    end else if (mult_Start && core_cnt == 0) begin
      core_cnt  <= busy_cycles;
      core_prod <= {4'b0, mult_A} * {4'b0, mult_x};
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [LI-1:0]   id;
    logic [2*LW-1:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [NR-1:0] mon_oh;

  int vectors     = 0;
  int miscompares = 0;
  int start_count = 0;
  int done_count  = 0;
  int done_cyc    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Delivery monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mult_Start) begin
        start_count++;
        if (!mult_Ready) checkOutput("start_while_busy", 32'(mult_Ready), 32'd1);
      end
      if (done !== '0) begin
        done_count++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = NR'(1) << mon_e.id;
          checkOutput("done_onehot", 32'(done), 32'(mon_oh));
          checkOutput("result_id", 32'(result_id), 32'(mon_e.id));
          checkOutput("result", 32'(result), 32'(mon_e.res));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*LW-1:0] a,
                               input logic [NR*LW-1:0] x);
    req  = r;
    A_in = a;
    x_in = x;
  endtask

  task automatic doReset();
    reset = 1'b1;
    req   = '0;
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic waitDones(input int n, input int budget);
    int target;
    int k;
    target = done_count + n;
    k = 0;
    while (done_count < target && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput("done_timeout", 32'(done_count), 32'(target));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int s0;
    int dc;

    reset       = 1'b1;
    req         = '0;
    A_in        = '0;
    x_in        = '0;
    busy_cycles = 0;

    // Reset state
    tick(2);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_start", 32'(mult_Start), 32'd0);
    reset = 1'b0;
    tick(1);

    // Single uncontended operation, 3*5 with a 6-cycle core
    $display("[TB] single operation");
    busy_cycles = 6;
    s0 = start_count;
    sb.push_back(exp_t'{1'b0, 8'h0F});
    applyStimulus(2'b01, {4'd0, 4'd3}, {4'd0, 4'd5});
    c0 = cyc;
    tick(1);
    checkOutput("t1_grant", 32'(grant), 32'h1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(2'b00, {4'd0, 4'd9}, {4'd0, 4'd9});
    waitDones(1, 50);
    checkOutput("t1_latency", 32'(done_cyc - c0), 32'd9);
    checkOutput("t1_mult_A_held", 32'(mult_A), 32'd3);
    checkOutput("t1_mult_x_held", 32'(mult_x), 32'd5);
    tick(3);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_grant_after", 32'(grant), 32'd0);
    checkOutput("t1_result_held", 32'(result), 32'h0F);
    checkOutput("t1_starts", 32'(start_count - s0), 32'd1);

    // Both requesting continuously: grants alternate 0,1,0,1
    $display("[TB] round robin");
    doReset();
    busy_cycles = 2;
    sb.push_back(exp_t'{1'b0, 8'd6});
    sb.push_back(exp_t'{1'b1, 8'd20});
    sb.push_back(exp_t'{1'b0, 8'd6});
    sb.push_back(exp_t'{1'b1, 8'd20});
    applyStimulus(2'b11, {4'd4, 4'd2}, {4'd5, 4'd3});
    waitDones(4, 200);
    applyStimulus(2'b00, {4'd4, 4'd2}, {4'd5, 4'd3});
    tick(4);
    checkOutput("t2_busy_after", 32'(busy), 32'd0);
    checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Zero multiplier with an immediately-ready core
    $display("[TB] zero operand");
    doReset();
    busy_cycles = 0;
    s0 = start_count;
    sb.push_back(exp_t'{1'b0, 8'd0});
    applyStimulus(2'b01, {4'd0, 4'd7}, {4'd0, 4'd0});
    c0 = cyc;
    tick(1);
    applyStimulus(2'b00, {4'd0, 4'd7}, {4'd0, 4'd0});
    waitDones(1, 20);
    checkOutput("t3_latency", 32'(done_cyc - c0), 32'(ZLAT));
    checkOutput("t3_starts", 32'(start_count - s0), 32'(ZSTART));
    tick(3);

    // Reset asserted while waiting on the core
    $display("[TB] reset during wait");
    doReset();
    busy_cycles = 6;
    sb.push_back(exp_t'{1'b0, 8'd15});
    applyStimulus(2'b01, {4'd0, 4'd3}, {4'd0, 4'd5});
    tick(1);
    applyStimulus(2'b00, {4'd0, 4'd3}, {4'd0, 4'd5});
    tick(2);
    checkOutput("t5_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("t5_grant", 32'(grant), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_start", 32'(mult_Start), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    busy_cycles = 2;
    sb.push_back(exp_t'{1'b0, 8'd6});
    applyStimulus(2'b11, {4'd4, 4'd2}, {4'd5, 4'd3});
    waitDones(1, 50);
    applyStimulus(2'b00, {4'd4, 4'd2}, {4'd5, 4'd3});
    tick(4);
    checkOutput("t5_busy_after", 32'(busy), 32'd0);

    // Requester 1 drops its request one cycle after the grant
    $display("[TB] request dropped after grant");
    busy_cycles = 3;
    s0 = start_count;
    sb.push_back(exp_t'{1'b1, 8'h51});
    applyStimulus(2'b10, {4'd9, 4'd0}, {4'd9, 4'd0});
    tick(1);
    checkOutput("t6_grant", 32'(grant), 32'h2);
    tick(1);
    applyStimulus(2'b00, {4'd0, 4'd0}, {4'd0, 4'd0});
    waitDones(1, 50);
    dc = done_count;
    tick(5);
    checkOutput("t6_grant_after", 32'(grant), 32'd0);
    checkOutput("t6_busy_after", 32'(busy), 32'd0);
    checkOutput("t6_no_repeat", 32'(done_count), 32'(dc));
    checkOutput("t6_starts", 32'(start_count - s0), 32'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
